// File: rtl/uart_pkg.sv
// uart_pkg: word width and receive FIFO depth shared by the UART receiver, transmitter and buffers.
//   DATA_BITS      width of a UART data word
//   FIFO_ADDR_BITS log2 of the receive FIFO depth
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int FIFO_ADDR_BITS = 4;
endpackage

// File: rtl/fifo_regfile.sv
// fifo_regfile: 2**AddrBits x DataBits storage, one synchronous write port and one asynchronous read port.
//   clk          rising-edge clock
//   we           write enable
//   waddr, wdata write address and data
//   raddr        read address
//   rdata        combinational read data at raddr
module fifo_regfile #(
    parameter int DataBits = 8,
    parameter int AddrBits = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AddrBits-1:0] waddr,
    input  logic [DataBits-1:0] wdata,
    input  logic [AddrBits-1:0] raddr,
    output logic [DataBits-1:0] rdata
);
    logic [DataBits-1:0] mem [2**AddrBits];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO capturing UART words on the done strobe, with sticky overrun.
//   clk, reset    clock and synchronous active-high reset
//   rx_done_tick  one-cycle strobe, rx_dout valid
//   rx_dout       received word
//   rd_en         host pop request, ignored while empty
//   rd_data       head word (zero while empty)
//   empty, full   occupancy flags derived from count
//   count         words stored, 0..2**AddrBits
//   overrun       sticky flag, a word was dropped while full
//   clr_overrun   clears overrun unless a drop happens in the same cycle
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DataBits = DATA_BITS,
    parameter int AddrBits = FIFO_ADDR_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_done_tick,
    input  logic [DataBits-1:0] rx_dout,
    input  logic                rd_en,
    output logic [DataBits-1:0] rd_data,
    output logic                empty,
    output logic                full,
    output logic [AddrBits:0]   count,
    output logic                overrun,
    input  logic                clr_overrun
);
    logic [AddrBits-1:0] wr_ptr, rd_ptr;
    logic [DataBits-1:0] head;
    logic                push, pop;

    assign empty = (count == '0);
    assign full  = (count == (AddrBits+1)'(2**AddrBits));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    assign push  = rx_done_tick & (~full | rd_en);
    assign pop   = rd_en & ~empty;
    // Storage is not reset; masking keeps rd_data at zero after reset.
    assign rd_data = empty ? '0 : head;

    fifo_regfile #(.DataBits(DataBits), .AddrBits(AddrBits)) u_regfile (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (rx_dout),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AddrBits{1'b0}}, push} - {{AddrBits{1'b0}}, pop};
            if (rx_done_tick & ~push) overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end
endmodule
